// File: rtl/keypad_scanner_if.sv
// Keypad matrix bus: row strobes out, column returns in, plus the debounced key result.
// master = scanner side, slave = matrix / key consumer side.
interface keypad_scanner_if #(
   parameter int unsigned ROWS = 4,
   parameter int unsigned COLS = 4
);
   localparam int unsigned CODE_W = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1;

   logic [COLS-1:0]   col_n;
   logic [ROWS-1:0]   row_n;
   logic [CODE_W-1:0] key_code;
   logic              key_valid;
   logic              key_held;

   modport master (
      input  col_n,
      output row_n,
      output key_code,
      output key_valid,
      output key_held
   );

   modport slave (
      output col_n,
      input  row_n,
      input  key_code,
      input  key_valid,
      input  key_held
   );
endinterface

// File: rtl/keypad_scanner.sv
// Keypad matrix scanner: strobes one row at a time, samples synchronized column returns,
// debounces whole-scan results and reports the lowest pressed key code.
// Optional feature macro: KEYPAD_REPEAT_EN (auto-repeat of key_valid while a key is held).
module keypad_scanner #(
   parameter int unsigned ROWS           = 4,
   parameter int unsigned COLS           = 4,
   parameter int unsigned SETTLE_CYCLES  = 4,
   parameter int unsigned DEBOUNCE_SCANS = 3,
   parameter int unsigned REPEAT_SCANS   = 64
) (
   input logic             clk,
   input logic             n_rst,
   keypad_scanner_if.master bus
);
   localparam int unsigned CODE_W = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1;
   localparam int unsigned ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int unsigned COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int unsigned SET_W  = $clog2(SETTLE_CYCLES);
   localparam int unsigned DEB_W  = $clog2(DEBOUNCE_SCANS + 1);

   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
   localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
   localparam logic [DEB_W-1:0] DEB_MAX  = DEB_W'(DEBOUNCE_SCANS);

   localparam logic [0:0] ST_SCAN = 1'b0;
   localparam logic [0:0] ST_EVAL = 1'b1;

`ifdef KEYPAD_REPEAT_EN
   localparam int unsigned REP_W = (REPEAT_SCANS > 1) ? $clog2(REPEAT_SCANS) : 1;
   localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_SCANS - 1);
   logic [REP_W-1:0] rep_q, rep_d;
`endif

   logic [COLS-1:0]   col_s1_q, col_s2_q;
   logic              started_q;
   logic [0:0]        state_q, state_d;
   logic [ROW_W-1:0]  row_q, row_d;
   logic [SET_W-1:0]  settle_q, settle_d;
   logic              found_q, found_d;
   logic [CODE_W-1:0] scan_key_q, scan_key_d;
   logic              cand_valid_q, cand_valid_d;
   logic [CODE_W-1:0] cand_key_q, cand_key_d;
   logic [DEB_W-1:0]  deb_q, deb_d;
   logic [CODE_W-1:0] key_code_q, key_code_d;
   logic              key_held_q, key_held_d;
   logic              key_valid_q, key_valid_d;
   logic [ROWS-1:0]   row_n_q, row_n_d;

   logic              row_hit;
   logic [COL_W-1:0]  hit_col;
   logic              same_as_cand;
   logic              differs_stable;

   // Two-flop synchronizer for the asynchronous column returns.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         col_s1_q <= '1;
         col_s2_q <= '1;
      end else begin
         col_s1_q <= bus.col_n;
         col_s2_q <= col_s1_q;
      end
   end

   // Lowest active-low column in the currently sampled row.
   always_comb begin
      row_hit = 1'b0;
      hit_col = '0;
      for (int c = int'(COLS) - 1; c >= 0; c--) begin
         if (!col_s2_q[c]) begin
            row_hit = 1'b1;
            hit_col = COL_W'(c);
         end
      end
   end

   // Scan result vs previous scan (NONE == not found) and vs the stable key.
   always_comb begin
      same_as_cand   = (found_q == cand_valid_q) && (!found_q || (scan_key_q == cand_key_q));
      differs_stable = (found_q != key_held_q) || (found_q && (scan_key_q != key_code_q));
   end

   // Scan/evaluate FSM and debounce next-state logic.
   always_comb begin
      state_d      = state_q;
      row_d        = row_q;
      settle_d     = settle_q;
      found_d      = found_q;
      scan_key_d   = scan_key_q;
      cand_valid_d = cand_valid_q;
      cand_key_d   = cand_key_q;
      deb_d        = deb_q;
      key_code_d   = key_code_q;
      key_held_d   = key_held_q;
      key_valid_d  = 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_d        = rep_q;
`endif

      // The first cycle after reset is spent with all rows released so row 0 gets a full
      // settle window once strobing starts.
      if (started_q) begin
         case (state_q)
            ST_SCAN: begin
               if (settle_q == SET_LAST) begin
                  settle_d = '0;
                  if (!found_q && row_hit) begin
                     found_d    = 1'b1;
                     scan_key_d = CODE_W'(32'(row_q) * COLS + 32'(hit_col));
                  end
                  if (row_q == ROW_LAST) begin
                     state_d = ST_EVAL;
                  end else begin
                     row_d = row_q + 1'b1;
                  end
               end else begin
                  settle_d = settle_q + 1'b1;
               end
            end

            ST_EVAL: begin
               cand_valid_d = found_q;
               cand_key_d   = scan_key_q;
               if (same_as_cand) begin
                  deb_d = (deb_q == DEB_MAX) ? deb_q : deb_q + 1'b1;
               end else begin
                  deb_d = DEB_W'(1);
               end

`ifdef KEYPAD_REPEAT_EN
               // Count scans that still see the held key; any other result clears it.
               if (key_held_q && found_q && (scan_key_q == key_code_q)) begin
                  if (rep_q == REP_LAST) begin
                     rep_d       = '0;
                     key_valid_d = 1'b1;
                  end else begin
                     rep_d = rep_q + 1'b1;
                  end
               end else begin
                  rep_d = '0;
               end
`endif

               if ((deb_d == DEB_MAX) && differs_stable) begin
                  if (found_q) begin
                     key_code_d  = scan_key_q;
                     key_held_d  = 1'b1;
                     key_valid_d = 1'b1;
                  end else begin
                     key_held_d = 1'b0;
                  end
               end

               found_d    = 1'b0;
               scan_key_d = '0;
               row_d      = '0;
               settle_d   = '0;
               state_d    = ST_SCAN;
            end

            default: state_d = ST_SCAN;
         endcase
      end

      // Row strobes are registered from the next state to keep the pins glitch-free.
      row_n_d = '1;
      if (state_d == ST_SCAN) begin
         row_n_d[row_d] = 1'b0;
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         started_q    <= 1'b0;
         state_q      <= ST_SCAN;
         row_q        <= '0;
         settle_q     <= '0;
         found_q      <= 1'b0;
         scan_key_q   <= '0;
         cand_valid_q <= 1'b0;
         cand_key_q   <= '0;
         deb_q        <= '0;
         key_code_q   <= '0;
         key_held_q   <= 1'b0;
         key_valid_q  <= 1'b0;
         row_n_q      <= '1;
      end else begin
         started_q    <= 1'b1;
         state_q      <= state_d;
         row_q        <= row_d;
         settle_q     <= settle_d;
         found_q      <= found_d;
         scan_key_q   <= scan_key_d;
         cand_valid_q <= cand_valid_d;
         cand_key_q   <= cand_key_d;
         deb_q        <= deb_d;
         key_code_q   <= key_code_d;
         key_held_q   <= key_held_d;
         key_valid_q  <= key_valid_d;
         row_n_q      <= row_n_d;
      end
   end

`ifdef KEYPAD_REPEAT_EN
   // Auto-repeat scan counter.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         rep_q <= '0;
      end else begin
         rep_q <= rep_d;
      end
   end
`endif

   assign bus.row_n     = row_n_q;
   assign bus.key_code  = key_code_q;
   assign bus.key_valid = key_valid_q;
   assign bus.key_held  = key_held_q;

endmodule
